// File: rtl/capture_readout.sv
// capture_readout: streams the capture buffer out oldest-first, one byte per
// valid/ready handshake, optionally clearing the buffer afterwards.
// Define CAPTURE_READOUT_HEADER_EN to prefix each dump with a 4-byte
// little-endian word count.
module capture_readout #(
  parameter int unsigned CAPTURE_WIDTH = 32,
  parameter int unsigned CAPTURE_SIZE  = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump_req,
  input  logic                     clear_after,
  input  logic [31:0]              capture_amount,
  input  logic [31:0]              capture_pos,
  output logic [31:0]              capture_rd_addr,
  input  logic [CAPTURE_WIDTH-1:0] capture_rd_data,
  output logic                     capture_reset,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW     = (CAPTURE_SIZE > 1) ? $clog2(CAPTURE_SIZE) : 1;
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned NBYTES = CAPTURE_WIDTH / 8;
  localparam int unsigned BMAX   = (NBYTES > 4) ? NBYTES : 4;
  localparam int unsigned BW     = $clog2(BMAX);
  localparam logic [31:0] SIZE32 = 32'(CAPTURE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef CAPTURE_READOUT_HEADER_EN
    S_HDR,
`endif
    S_READ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic                     clear_q, clear_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            words_left_q, words_left_d;
  logic [CAPTURE_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]              rd_addr_q, rd_addr_d;

  logic [31:0]              amt_clamped;
  logic [AW-1:0]            start_ptr;
  logic                     unused_pos;

`ifdef CAPTURE_READOUT_HEADER_EN
  logic [31:0]              hdr_word;
  // words_left still equals the snapshot count while the header is sent
  assign hdr_word = 32'(words_left_q);
`endif

  // Snapshot inputs: clamp the fill level; a full buffer starts at the write pointer
  always_comb begin
    amt_clamped = (capture_amount > SIZE32) ? SIZE32 : capture_amount;
    start_ptr   = (amt_clamped == SIZE32) ? capture_pos[AW-1:0] : '0;
  end

  assign unused_pos = ^capture_pos[31:AW];

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    clear_d         = clear_q;
    rd_ptr_d        = rd_ptr_q;
    words_left_d    = words_left_q;
    shift_d         = shift_q;
    byte_idx_d      = byte_idx_q;
    rd_addr_d       = rd_addr_q;

    capture_rd_addr = rd_addr_q;
    capture_reset   = 1'b0;
    out_data        = '0;
    out_valid       = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (dump_req) begin
          words_left_d = CW'(amt_clamped);
          clear_d      = clear_after;
          rd_ptr_d     = start_ptr;
          byte_idx_d   = '0;
`ifdef CAPTURE_READOUT_HEADER_EN
          state_d      = S_HDR;
`else
          state_d      = (amt_clamped != '0) ? S_READ : S_FIN;
`endif
        end
      end

`ifdef CAPTURE_READOUT_HEADER_EN
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = 8'(hdr_word >> {byte_idx_q, 3'b000});
        if (out_ready) begin
          if (byte_idx_q == BW'(3)) begin
            byte_idx_d = '0;
            state_d    = (words_left_q != '0) ? S_READ : S_FIN;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
`endif

      S_READ: begin
        capture_rd_addr = 32'(rd_ptr_q);
        rd_addr_d       = 32'(rd_ptr_q);
        state_d         = S_WAIT;
      end

      S_WAIT: begin
        shift_d    = capture_rd_data;
        byte_idx_d = '0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
        out_data  = shift_q[7:0];
        if (out_ready) begin
          shift_d = shift_q >> 8;
          if (byte_idx_q == BW'(NBYTES - 1)) begin
            byte_idx_d   = '0;
            rd_ptr_d     = rd_ptr_q + AW'(1);
            words_left_d = words_left_q - CW'(1);
            state_d      = (words_left_q != CW'(1)) ? S_READ : S_FIN;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end

      S_FIN: begin
        done          = 1'b1;
        capture_reset = clear_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clear_q      <= 1'b0;
      rd_ptr_q     <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      clear_q      <= clear_d;
      rd_ptr_q     <= rd_ptr_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

endmodule

// File: doc/capture_readout.md
# capture_readout

Downstream readout engine for the capture buffer. On request it snapshots the buffer's fill level and write pointer, reads the stored words back through the buffer's read port in chronological order (oldest first, unrolling circular wrap), and streams them out byte-by-byte on a valid/ready interface toward the host link. Optionally prefixes a length header and clears the buffer once the dump completes.

## Interface

- `CAPTURE_WIDTH`, 32: stored word width in bits; must be a multiple of 8.
- `CAPTURE_SIZE`, 128: buffer depth in words; must be a power of two, at least 2.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `dump_req`  in  1  one-cycle request to start a dump; ignored while `busy`.
- `clear_after`  in  1  sampled with `dump_req`; 1 = pulse `capture_reset` when the dump completes.
- `capture_amount`  in  32  number of valid words in the buffer.
- `capture_pos`  in  32  buffer next-write address.
- `capture_rd_addr`  out  32  buffer read address; RAM read data is valid 1 cycle later.
- `capture_rd_data`  in  CAPTURE_WIDTH  buffer read data.
- `capture_reset`  out  1  one-cycle clear pulse to the buffer.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte on a cycle where `out_valid && out_ready`.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when the dump finishes.

## Operation

- States: IDLE, HDR, READ, WAIT, SEND, FIN.
- IDLE: on `dump_req`, snapshot `count = capture_amount`, `clear = clear_after`, and `start = (capture_amount == CAPTURE_SIZE) ? (capture_pos & (CAPTURE_SIZE-1)) : 0`. Go to HDR if the header is enabled, otherwise to READ if `count != 0`, otherwise to FIN.
- HDR: emit 4 bytes of `count`, little-endian, one byte per handshake. Then go to READ, or to FIN if `count == 0`.
- READ: drive `capture_rd_addr = rd_ptr` (initialised to `start`), then go to WAIT.
- WAIT: in the next cycle, latch `capture_rd_data` into the shift register, then go to SEND.
- SEND: emit `CAPTURE_WIDTH/8` bytes, LSB byte first (byte 0 = bits [7:0]), one per handshake. After the last byte's handshake:
  - `rd_ptr = (rd_ptr + 1) mod CAPTURE_SIZE`
  - `words_left -= 1`
  - go to READ if `words_left != 0`, else to FIN.
- FIN: for one cycle, assert `done` and assert `capture_reset = clear`. Go to IDLE.
- Stream rules:
  - `out_data` is held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
  - `out_valid` is 0 outside HDR and SEND.
- `busy` = 1 in every state except IDLE.
- `capture_rd_addr` holds its last value outside READ. It is a 32-bit zero-extended address.
- Inputs `capture_amount` and `capture_pos` are ignored after the snapshot, so the buffer may keep capturing without corrupting the dump.
- `capture_amount > CAPTURE_SIZE` is clamped to `CAPTURE_SIZE`.
- Reset values: state IDLE, `capture_rd_addr` 0, `out_data` 0, `out_valid` 0, `busy` 0, `done` 0, `capture_reset` 0.
- Reset mid-dump: all outputs return to reset values immediately. No `done` pulse and no `capture_reset` pulse are produced.

## Timing

- `dump_req` sampled in cycle N:
  - `busy` = 1 in N+1.
  - Without header: READ in N+1, WAIT in N+2, first data byte `out_valid` in N+3.
  - With header: first header byte valid in N+1.
- With `out_ready` held at 1: one byte per cycle within a word, plus a 2-cycle `out_valid` gap (READ, WAIT) between words.
- Total dump with `out_ready` = 1, no header: `count*(CAPTURE_WIDTH/8 + 2) + 1` cycles, then `done` in the following cycle.
- `count == 0`, no header: `done` in N+1.
- `dump_req` coincident with FIN is ignored. `busy` is still 1 in that cycle.

## Configuration

- `CAPTURE_READOUT_HEADER_EN` defined: HDR state compiled in; every dump begins with a 4-byte little-endian word count.
- Not defined: HDR is absent and the stream contains data bytes only.

## Test plan

- No header, `amount`=5, `pos`=5, RAM[i]=0xA0B0C000+i, `out_ready`=1 -> 20 bytes 00 C0 B0 A0 01 C0 B0 A0 … 04 C0 B0 A0; `capture_rd_addr` sequence 0..4; `done` 1 cycle after the last byte.
- Circular full, `amount`=128, `pos`=37 -> read addresses 37..127 then 0..36; exactly 512 bytes.
- Backpressure: `out_ready` low for 3 cycles on byte 2 of word 0 -> `out_data` and `out_valid` stable throughout; no byte lost or duplicated.
- `amount`=0, `clear_after`=1, no header -> `done` and `capture_reset` pulse in N+1; `out_valid` never asserted.
- With `CAPTURE_READOUT_HEADER_EN`, `amount`=5 -> bytes 05 00 00 00 starting at N+1, followed by the 20 data bytes; second `dump_req` while `busy` ignored.
- Assert `reset` during word 2 of a dump -> `out_valid`, `busy`, `capture_reset` go 0 at once; no `done` pulse; a new dump afterwards starts from `start` again.
